// File: rtl/msg_link_pkg.sv
// msg_link_pkg: shared defaults and helpers for the msg_link message channel.
//   DEF_WIDTH / DEF_DEPTH / DEF_SEQ_W : default payload width, buffer depth,
//                                       sequence-number width.
//   cnt_w(depth)                      : width of an occupancy count able to
//                                       hold 0..depth inclusive.
package msg_link_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_SEQ_W = 8;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/msg_fifo.sv
// msg_fifo: one direction of the message link. First-word-fall-through
// buffer that tags each accepted payload with a wrapping sequence number.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   in_send, in_msg   : producer offers a payload
//   in_ready          : buffer has room (registered occupancy < DEPTH)
//   in_overflow       : sticky, producer sent while in_ready was 0
//   out_valid         : head message presented
//   out_msg, out_seq  : head payload and sequence tag (0 when empty)
//   out_ack           : consumer pops the head
//   count             : current occupancy
module msg_fifo
  import msg_link_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int SEQ_W = DEF_SEQ_W,
  parameter int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_send,
  input  logic [WIDTH-1:0] in_msg,
  output logic             in_ready,
  output logic             in_overflow,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_msg,
  output logic [SEQ_W-1:0] out_seq,
  input  logic             out_ack,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Storage carries no reset; only the control state below is cleared.
  logic [WIDTH-1:0] data_mem_q [DEPTH];
  logic [SEQ_W-1:0] seq_mem_q  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             ovf_q, ovf_d;
  logic             full, push, pop;

  always_comb begin
    // Fullness looks only at registered occupancy, so a same-cycle pop
    // never frees room for a send.
    full     = (count_q == FULL_CNT);
    push     = in_send && !full;
    pop      = out_ack && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    seq_d    = seq_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      seq_d    = seq_q + SEQ_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    ovf_d   = ovf_q | (in_send & full);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      seq_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      seq_q    <= seq_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      data_mem_q[wr_ptr_q] <= in_msg;
      seq_mem_q[wr_ptr_q]  <= seq_q;
    end
  end

  assign in_ready    = !full;
  assign in_overflow = ovf_q;
  assign out_valid   = (count_q != '0);
  assign out_msg     = out_valid ? data_mem_q[rd_ptr_q] : '0;
  assign out_seq     = out_valid ? seq_mem_q[rd_ptr_q] : '0;
  assign count       = count_q;

endmodule

// File: rtl/msg_link.sv
// msg_link: bidirectional message link between machines A and B, built from
// two independent msg_fifo instances (A->B and B->A).
// Ports:
//   clk, reset                               : clock, sync active-high reset
//   a_send, a_msg, a_ready, a_overflow       : A's producer side (to B)
//   b_valid, b_msg, b_seq, b_ack             : B's consumer side (from A)
//   b_send, b_msg_in, b_ready, b_overflow    : B's producer side (to A)
//   a_valid, a_msg_out, a_seq, a_ack         : A's consumer side (from B)
//   ab_count, ba_count                       : occupancy of each buffer
module msg_link
  import msg_link_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int SEQ_W = DEF_SEQ_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      a_send,
  input  logic [WIDTH-1:0]          a_msg,
  output logic                      a_ready,
  output logic                      a_overflow,
  output logic                      b_valid,
  output logic [WIDTH-1:0]          b_msg,
  output logic [SEQ_W-1:0]          b_seq,
  input  logic                      b_ack,
  input  logic                      b_send,
  input  logic [WIDTH-1:0]          b_msg_in,
  output logic                      b_ready,
  output logic                      b_overflow,
  output logic                      a_valid,
  output logic [WIDTH-1:0]          a_msg_out,
  output logic [SEQ_W-1:0]          a_seq,
  input  logic                      a_ack,
  output logic [cnt_w(DEPTH)-1:0]   ab_count,
  output logic [cnt_w(DEPTH)-1:0]   ba_count
);

  msg_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SEQ_W(SEQ_W)) u_ab (
    .clk        (clk),
    .reset      (reset),
    .in_send    (a_send),
    .in_msg     (a_msg),
    .in_ready   (a_ready),
    .in_overflow(a_overflow),
    .out_valid  (b_valid),
    .out_msg    (b_msg),
    .out_seq    (b_seq),
    .out_ack    (b_ack),
    .count      (ab_count)
  );

  msg_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SEQ_W(SEQ_W)) u_ba (
    .clk        (clk),
    .reset      (reset),
    .in_send    (b_send),
    .in_msg     (b_msg_in),
    .in_ready   (b_ready),
    .in_overflow(b_overflow),
    .out_valid  (a_valid),
    .out_msg    (a_msg_out),
    .out_seq    (a_seq),
    .out_ack    (a_ack),
    .count      (ba_count)
  );

endmodule

// File: tb/tb_msg_link.sv
// tb_msg_link: directed self-checking bench for msg_link (defaults:
// WIDTH=32, DEPTH=4, SEQ_W=8).
module tb_msg_link;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_send, b_send, a_ack, b_ack;
  logic [31:0] a_msg, b_msg_in;
  logic        a_ready, a_overflow, b_valid, b_ready, b_overflow, a_valid;
  logic [31:0] b_msg, a_msg_out;
  logic [7:0]  b_seq, a_seq;
  logic [2:0]  ab_count, ba_count;

  int checks = 0;
  int failures = 0;

  msg_link dut (
    .clk       (clk),
    .reset     (reset),
    .a_send    (a_send),
    .a_msg     (a_msg),
    .a_ready   (a_ready),
    .a_overflow(a_overflow),
    .b_valid   (b_valid),
    .b_msg     (b_msg),
    .b_seq     (b_seq),
    .b_ack     (b_ack),
    .b_send    (b_send),
    .b_msg_in  (b_msg_in),
    .b_ready   (b_ready),
    .b_overflow(b_overflow),
    .a_valid   (a_valid),
    .a_msg_out (a_msg_out),
    .a_seq     (a_seq),
    .a_ack     (a_ack),
    .ab_count  (ab_count),
    .ba_count  (ba_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Inputs change 1 time unit after the rising edge; outputs are read there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_send = 1'b0; b_send = 1'b0; a_ack = 1'b0; b_ack = 1'b0;
    a_msg = '0; b_msg_in = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL rst_a_ready got=%0b exp=1", a_ready); end
    checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL rst_b_ready got=%0b exp=1", b_ready); end
    checks++; if (b_valid !== 1'b0 || a_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got b=%0b a=%0b exp=0", b_valid, a_valid); end
    checks++; if (b_msg !== 32'd0 || b_seq !== 8'd0) begin failures++; $display("FAIL rst_b_out got msg=%0d seq=%0d exp=0", b_msg, b_seq); end
    checks++; if (a_msg_out !== 32'd0 || a_seq !== 8'd0) begin failures++; $display("FAIL rst_a_out got msg=%0d seq=%0d exp=0", a_msg_out, a_seq); end
    checks++; if (ab_count !== 3'd0 || ba_count !== 3'd0) begin failures++; $display("FAIL rst_count got ab=%0d ba=%0d exp=0", ab_count, ba_count); end
    checks++; if (a_overflow !== 1'b0 || b_overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf got a=%0b b=%0b exp=0", a_overflow, b_overflow); end
  endtask

  task automatic test_basic();
    do_reset();
    a_send = 1'b1; a_msg = 32'd100;
    step();
    checks++; if (b_valid !== 1'b1 || b_msg !== 32'd100 || b_seq !== 8'd0) begin failures++; $display("FAIL basic_first got v=%0b msg=%0d seq=%0d exp v=1 msg=100 seq=0", b_valid, b_msg, b_seq); end
    a_msg = 32'd200;
    step();
    a_send = 1'b0;
    checks++; if (ab_count !== 3'd2 || b_msg !== 32'd100) begin failures++; $display("FAIL basic_two got cnt=%0d msg=%0d exp cnt=2 msg=100", ab_count, b_msg); end
    b_ack = 1'b1;
    step();
    checks++; if (b_valid !== 1'b1 || b_msg !== 32'd200 || b_seq !== 8'd1) begin failures++; $display("FAIL basic_second got v=%0b msg=%0d seq=%0d exp v=1 msg=200 seq=1", b_valid, b_msg, b_seq); end
    step();
    checks++; if (b_valid !== 1'b0 || b_msg !== 32'd0 || b_seq !== 8'd0 || ab_count !== 3'd0) begin failures++; $display("FAIL basic_empty got v=%0b msg=%0d seq=%0d cnt=%0d exp 0", b_valid, b_msg, b_seq, ab_count); end
    step();
    b_ack = 1'b0;
    checks++; if (ab_count !== 3'd0 || b_valid !== 1'b0) begin failures++; $display("FAIL basic_ack_empty got cnt=%0d v=%0b exp 0", ab_count, b_valid); end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    a_send = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_msg = 32'd10 + 32'(i);
      step();
    end
    checks++; if (a_ready !== 1'b0 || ab_count !== 3'd4 || a_overflow !== 1'b0) begin failures++; $display("FAIL fill_full got rdy=%0b cnt=%0d ovf=%0b exp rdy=0 cnt=4 ovf=0", a_ready, ab_count, a_overflow); end
    a_msg = 32'd99;
    step();
    a_send = 1'b0;
    checks++; if (a_overflow !== 1'b1 || ab_count !== 3'd4) begin failures++; $display("FAIL fill_ovf got ovf=%0b cnt=%0d exp ovf=1 cnt=4", a_overflow, ab_count); end
    b_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (b_msg !== 32'd10 + 32'(i) || b_seq !== 8'(i)) begin failures++; $display("FAIL fill_pop%0d got msg=%0d seq=%0d exp msg=%0d seq=%0d", i, b_msg, b_seq, 10 + i, i); end
      step();
    end
    b_ack = 1'b0;
    checks++; if (ab_count !== 3'd0 || a_overflow !== 1'b1) begin failures++; $display("FAIL fill_drained got cnt=%0d ovf=%0b exp cnt=0 ovf=1", ab_count, a_overflow); end
    a_send = 1'b1; a_msg = 32'd55;
    step();
    a_send = 1'b0;
    checks++; if (b_msg !== 32'd55 || b_seq !== 8'd4) begin failures++; $display("FAIL fill_next_seq got msg=%0d seq=%0d exp msg=55 seq=4", b_msg, b_seq); end
  endtask

  task automatic test_full_send_ack();
    do_reset();
    a_send = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_msg = 32'd20 + 32'(i);
      step();
    end
    a_msg = 32'd77; b_ack = 1'b1;
    step();
    a_send = 1'b0;
    checks++; if (ab_count !== 3'd3 || a_ready !== 1'b1 || a_overflow !== 1'b1) begin failures++; $display("FAIL fullsa got cnt=%0d rdy=%0b ovf=%0b exp cnt=3 rdy=1 ovf=1", ab_count, a_ready, a_overflow); end
    for (int i = 1; i < 4; i++) begin
      checks++; if (b_msg !== 32'd20 + 32'(i) || b_seq !== 8'(i)) begin failures++; $display("FAIL fullsa_pop%0d got msg=%0d seq=%0d exp msg=%0d seq=%0d", i, b_msg, b_seq, 20 + i, i); end
      step();
    end
    b_ack = 1'b0;
    checks++; if (b_valid !== 1'b0 || ab_count !== 3'd0) begin failures++; $display("FAIL fullsa_empty got v=%0b cnt=%0d exp 0", b_valid, ab_count); end
  endtask

  task automatic test_stream();
    do_reset();
    a_send = 1'b1; a_msg = 32'd1000;
    step();
    b_ack = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_msg = 32'd1000 + 32'(i);
      checks++; if (b_msg !== 32'd1000 + 32'(i - 1) || b_seq !== 8'(i - 1)) begin failures++; $display("FAIL stream_head%0d got msg=%0d seq=%0d exp msg=%0d seq=%0d", i, b_msg, b_seq, 999 + i, i - 1); end
      step();
      checks++; if (ab_count !== 3'd1) begin failures++; $display("FAIL stream_cnt%0d got=%0d exp=1", i, ab_count); end
    end
    a_send = 1'b0;
    checks++; if (b_msg !== 32'd1008 || b_seq !== 8'd8) begin failures++; $display("FAIL stream_last got msg=%0d seq=%0d exp msg=1008 seq=8", b_msg, b_seq); end
    step();
    b_ack = 1'b0;
    checks++; if (ab_count !== 3'd0) begin failures++; $display("FAIL stream_end got cnt=%0d exp=0", ab_count); end
  endtask

  task automatic test_seq_wrap();
    do_reset();
    a_send = 1'b1; b_send = 1'b1; a_ack = 1'b1; b_ack = 1'b1;
    for (int i = 0; i < 260; i++) begin
      a_msg = 32'(i);
      b_msg_in = 32'hA000_0000 + 32'(i);
      if (i > 0) begin
        checks++; if (b_msg !== 32'(i - 1) || b_seq !== 8'(i - 1)) begin failures++; $display("FAIL wrap_ab%0d got msg=%0d seq=%0d exp msg=%0d seq=%0d", i, b_msg, b_seq, i - 1, (i - 1) % 256); end
        checks++; if (a_msg_out !== 32'hA000_0000 + 32'(i - 1) || a_seq !== 8'(i - 1)) begin failures++; $display("FAIL wrap_ba%0d got msg=%h seq=%0d exp msg=%h seq=%0d", i, a_msg_out, a_seq, 32'hA000_0000 + 32'(i - 1), (i - 1) % 256); end
      end
      step();
    end
    a_send = 1'b0; b_send = 1'b0;
    checks++; if (b_msg !== 32'd259 || b_seq !== 8'd3) begin failures++; $display("FAIL wrap_ab_last got msg=%0d seq=%0d exp msg=259 seq=3", b_msg, b_seq); end
    checks++; if (a_msg_out !== 32'hA000_0103 || a_seq !== 8'd3) begin failures++; $display("FAIL wrap_ba_last got msg=%h seq=%0d exp msg=a0000103 seq=3", a_msg_out, a_seq); end
    step();
    a_ack = 1'b0; b_ack = 1'b0;
    checks++; if (ab_count !== 3'd0 || ba_count !== 3'd0) begin failures++; $display("FAIL wrap_end got ab=%0d ba=%0d exp 0", ab_count, ba_count); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    a_send = 1'b1; b_send = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_send = (i < 3);
      a_msg = 32'd300 + 32'(i);
      b_msg_in = 32'd400 + 32'(i);
      step();
    end
    a_send = 1'b0; b_send = 1'b0;
    checks++; if (ab_count !== 3'd3 || ba_count !== 3'd4 || b_overflow !== 1'b1) begin failures++; $display("FAIL mid_pre got ab=%0d ba=%0d bovf=%0b exp ab=3 ba=4 bovf=1", ab_count, ba_count, b_overflow); end
    reset = 1'b1; a_send = 1'b1; b_ack = 1'b1; a_msg = 32'd999;
    step();
    reset = 1'b0; a_send = 1'b0; b_ack = 1'b0;
    checks++; if (b_valid !== 1'b0 || a_valid !== 1'b0 || ab_count !== 3'd0 || ba_count !== 3'd0) begin failures++; $display("FAIL mid_rst got bv=%0b av=%0b ab=%0d ba=%0d exp 0", b_valid, a_valid, ab_count, ba_count); end
    checks++; if (a_overflow !== 1'b0 || b_overflow !== 1'b0 || a_ready !== 1'b1 || b_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_flags got aovf=%0b bovf=%0b ardy=%0b brdy=%0b exp ovf=0 rdy=1", a_overflow, b_overflow, a_ready, b_ready); end
    a_send = 1'b1; a_msg = 32'd555; b_send = 1'b1; b_msg_in = 32'd666;
    step();
    a_send = 1'b0; b_send = 1'b0;
    checks++; if (b_msg !== 32'd555 || b_seq !== 8'd0 || ab_count !== 3'd1) begin failures++; $display("FAIL mid_ab_restart got msg=%0d seq=%0d cnt=%0d exp msg=555 seq=0 cnt=1", b_msg, b_seq, ab_count); end
    checks++; if (a_msg_out !== 32'd666 || a_seq !== 8'd0) begin failures++; $display("FAIL mid_ba_restart got msg=%0d seq=%0d exp msg=666 seq=0", a_msg_out, a_seq); end
  endtask

  initial begin
    reset = 1'b1;
    a_send = 1'b0; b_send = 1'b0; a_ack = 1'b0; b_ack = 1'b0;
    a_msg = '0; b_msg_in = '0;
    step();
    test_reset();
    test_basic();
    test_fill_overflow();
    test_full_send_ack();
    test_stream();
    test_seq_wrap();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/msg_link.md
MSG_LINK -- requirements
Module: msg_link

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the message payload width in bits.
REQ-002 Parameter DEPTH, default 4, power of two >= 2, SHALL set the message buffer depth per direction.
REQ-003 Parameter SEQ_W, default 8, SHALL set the sequence-number width in bits.
REQ-004 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port a_send, input, 1: machine A offers a message to B this cycle.
REQ-007 Port a_msg, input, WIDTH: payload from A.
REQ-008 Port a_ready, output, 1: the A->B buffer can accept a message.
REQ-009 Port a_overflow, output, 1: sticky flag, A sent while a_ready was 0.
REQ-010 Port b_valid, output, 1: a message for B is presented.
REQ-011 Port b_msg, output, WIDTH: head payload for B.
REQ-012 Port b_seq, output, SEQ_W: sequence number of the head message for B.
REQ-013 Port b_ack, input, 1: B consumes the presented message.
REQ-014 Ports b_send, b_msg_in, b_ready, b_overflow, a_valid, a_msg_out, a_seq and a_ack SHALL mirror REQ-006 to REQ-013 for the B->A direction, with identical widths.
REQ-015 Port ab_count and ba_count, output, clog2(DEPTH)+1: occupancy of each buffer.

Function (stated for A->B; B->A identical and independent)
REQ-016 ready SHALL be 1 exactly when occupancy < DEPTH.
REQ-017 A message SHALL be accepted on a cycle where send=1 and ready=1; the payload and current sequence number are written at the tail.
REQ-018 The sequence counter SHALL increment by 1 only on acceptance and wrap from 2^SEQ_W-1 to 0.
REQ-019 valid SHALL be 1 exactly when occupancy > 0; the head is shown first-word-fall-through, so an accepted message appears at the receiver the cycle after acceptance (1-cycle latency).
REQ-020 While valid=0, the receiver's msg and seq outputs SHALL be driven to 0.
REQ-021 A message SHALL be popped on a cycle where valid=1 and ack=1; ack while valid=0 has no effect.
REQ-022 On simultaneous accept and pop, occupancy SHALL be unchanged and both pointers SHALL advance.
REQ-023 When full, send SHALL NOT be accepted even if a pop occurs in the same cycle; ready reflects only the registered occupancy.
REQ-024 When send=1 and ready=0, the message SHALL be dropped, the sequence counter SHALL NOT change, and overflow SHALL be set from the next cycle until reset.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH; messages SHALL be delivered in acceptance order with no loss or duplication.

Reset
REQ-026 While reset=1 at a clock edge, pointers, occupancy, sequence counters and overflow flags SHALL clear to 0 and send/ack SHALL be ignored.
REQ-027 After reset, ready=1, valid=0, msg=0, seq=0 and count=0 in both directions; any in-flight messages are discarded.

Structure
REQ-028 A shared package msg_link_pkg SHALL hold the default WIDTH, DEPTH and SEQ_W constants and a function computing the count width.
REQ-029 One sub-module, msg_fifo (parametrised FWFT buffer with count and sequence tagging), SHALL be instantiated twice, once per direction.

Verification
REQ-030 After reset, A sends 32'd100, 32'd200 -> B sees b_valid one cycle after each acceptance, with b_msg=100/seq=0 then 200/seq=1 on successive b_ack.
REQ-031 A sends 4 messages with b_ack=0 (DEPTH=4) -> a_ready=0, ab_count=4; a 5th send sets a_overflow; after the 4 pops the sequence numbers seen are 0..3 and the next accepted message has seq=4.
REQ-032 Buffer full, send and ack in the same cycle -> the send is rejected, ab_count=3, and a_ready=1 on the next cycle.
REQ-033 Steady send+ack every cycle with occupancy 1 -> ab_count stays 1 and the stream is delivered in order.
REQ-034 260 accepted messages with SEQ_W=8 -> seq wraps 255->0; both directions run concurrently with no cross-talk.
REQ-035 Reset asserted with 3 messages buffered -> next cycle both valids=0, counts=0, overflows=0, seq restarts at 0.
